// File: rtl/reg_writeback.sv
// reg_writeback: merges a fixed-latency ALU result stream (A) and a
// backpressured load result stream (B) onto one registered register-file
// write port. The matching bypass packet is taken from the same register.
// B results that lose the port wait in an in-order circular FIFO.
module reg_writeback #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 7,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              recoverFlag_i,
    input  logic              aValid_i,
    input  logic              aDestValid_i,
    input  logic [TAG_W-1:0]  aPhyDest_i,
    input  logic [DATA_W-1:0] aData_i,
    input  logic              bValid_i,
    input  logic              bDestValid_i,
    input  logic [TAG_W-1:0]  bPhyDest_i,
    input  logic [DATA_W-1:0] bData_i,
    output logic              bReady_o,
    output logic              wrEn_o,
    output logic [TAG_W-1:0]  wrAddr_o,
    output logic [DATA_W-1:0] wrData_o,
    output logic              bypValid_o,
    output logic [TAG_W-1:0]  bypTag_o,
    output logic [DATA_W-1:0] bypData_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [TAG_W-1:0]  tag_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W:0]    count;

    logic              req_a;
    logic              req_b;
    logic              fifo_empty;
    logic              deq;
    logic              direct_b;
    logic              enq;

    logic              win_valid;
    logic [TAG_W-1:0]  win_tag;
    logic [DATA_W-1:0] win_data;

    logic              wr_en;
    logic [TAG_W-1:0]  wr_addr;
    logic [DATA_W-1:0] wr_data;

    // Ready depends only on the registered occupancy, so a full FIFO keeps
    // ready low even in a cycle where it is draining.
    assign bReady_o   = (count < CNT_FULL);
    assign fifo_empty = (count == '0);

    // Port arbitration: A always wins, then the oldest buffered B, then a
    // fresh B straight through; a fresh B that does not go direct is queued.
    always_comb begin
        req_a     = aValid_i & aDestValid_i;
        req_b     = bValid_i & bDestValid_i & bReady_o;
        deq       = 1'b0;
        direct_b  = 1'b0;
        enq       = 1'b0;
        win_valid = 1'b0;
        win_tag   = wr_addr;
        win_data  = wr_data;
        if (req_a) begin
            win_valid = 1'b1;
            win_tag   = aPhyDest_i;
            win_data  = aData_i;
        end else if (!fifo_empty) begin
            deq       = 1'b1;
            win_valid = 1'b1;
            win_tag   = tag_mem[head];
            win_data  = data_mem[head];
        end else if (req_b) begin
            direct_b  = 1'b1;
            win_valid = 1'b1;
            win_tag   = bPhyDest_i;
            win_data  = bData_i;
        end
        enq = req_b & ~direct_b;
    end

    // FIFO pointer and occupancy bookkeeping; a flush empties the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (recoverFlag_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + PTR_ONE;
            if (deq) head <= head + PTR_ONE;
            case ({enq, deq})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // FIFO payload storage; contents are don't-care until counted valid.
    always_ff @(posedge clk) begin
        if (enq && !recoverFlag_i) begin
            tag_mem[tail]  <= bPhyDest_i;
            data_mem[tail] <= bData_i;
        end
    end

    // Registered write port; tag and data hold their last value when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (recoverFlag_i) begin
            wr_en   <= 1'b0;
        end else begin
            wr_en   <= win_valid;
            wr_addr <= win_tag;
            wr_data <= win_data;
        end
    end

    assign wrEn_o     = wr_en;
    assign wrAddr_o   = wr_addr;
    assign wrData_o   = wr_data;
    assign bypValid_o = wr_en;
    assign bypTag_o   = wr_addr;
    assign bypData_o  = wr_data;

endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: table-driven single-transaction vectors plus multi-cycle
// sequences, with a negedge scoreboard that predicts every port write.
module tb_reg_writeback;

    localparam int DATA_W = 64;
    localparam int TAG_W  = 7;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              reset;
    logic              recoverFlag_i;
    logic              aValid_i;
    logic              aDestValid_i;
    logic [TAG_W-1:0]  aPhyDest_i;
    logic [DATA_W-1:0] aData_i;
    logic              bValid_i;
    logic              bDestValid_i;
    logic [TAG_W-1:0]  bPhyDest_i;
    logic [DATA_W-1:0] bData_i;
    logic              bReady_o;
    logic              wrEn_o;
    logic [TAG_W-1:0]  wrAddr_o;
    logic [DATA_W-1:0] wrData_o;
    logic              bypValid_o;
    logic [TAG_W-1:0]  bypTag_o;
    logic [DATA_W-1:0] bypData_o;

    int compared   = 0;
    int mismatched = 0;

    reg_writeback #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .recoverFlag_i(recoverFlag_i),
        .aValid_i     (aValid_i),
        .aDestValid_i (aDestValid_i),
        .aPhyDest_i   (aPhyDest_i),
        .aData_i      (aData_i),
        .bValid_i     (bValid_i),
        .bDestValid_i (bDestValid_i),
        .bPhyDest_i   (bPhyDest_i),
        .bData_i      (bData_i),
        .bReady_o     (bReady_o),
        .wrEn_o       (wrEn_o),
        .wrAddr_o     (wrAddr_o),
        .wrData_o     (wrData_o),
        .bypValid_o   (bypValid_o),
        .bypTag_o     (bypTag_o),
        .bypData_o    (bypData_o)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rec, input logic av, input logic adv,
                                 input logic [TAG_W-1:0] at, input logic [DATA_W-1:0] ad,
                                 input logic bv, input logic bdv,
                                 input logic [TAG_W-1:0] bt, input logic [DATA_W-1:0] bd);
        recoverFlag_i = rec;
        aValid_i      = av;
        aDestValid_i  = adv;
        aPhyDest_i    = at;
        aData_i       = ad;
        bValid_i      = bv;
        bDestValid_i  = bdv;
        bPhyDest_i    = bt;
        bData_i       = bd;
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    // Scoreboard: B results in acceptance order, plus the A result (if any)
    // that must own the port on the next edge.
    logic [TAG_W+DATA_W-1:0] b_q [$];
    logic                    exp_a      = 1'b0;
    logic [TAG_W-1:0]        exp_a_tag  = '0;
    logic [DATA_W-1:0]       exp_a_data = '0;

    // Negedge monitor: check the write made on the last edge, then sample
    // the inputs that the coming edge will act upon.
    always @(negedge clk) begin
        logic [TAG_W+DATA_W-1:0] ent;
        if (reset) begin
            checkOutput("mon_reset_wr_en", wrEn_o, 1'b0);
            b_q.delete();
            exp_a = 1'b0;
        end else begin
            checkOutput("mon_byp_valid", bypValid_o, wrEn_o);
            if (exp_a) begin
                checkOutput("mon_a_wr_en", wrEn_o, 1'b1);
                checkOutput("mon_a_tag", wrAddr_o, exp_a_tag);
                checkOutput("mon_a_data", wrData_o, exp_a_data);
                checkOutput("mon_a_byp_tag", bypTag_o, exp_a_tag);
            end else if (b_q.size() > 0) begin
                ent = b_q.pop_front();
                checkOutput("mon_b_wr_en", wrEn_o, 1'b1);
                checkOutput("mon_b_tag", wrAddr_o, ent[TAG_W+DATA_W-1:DATA_W]);
                checkOutput("mon_b_data", wrData_o, ent[DATA_W-1:0]);
                checkOutput("mon_b_byp_data", bypData_o, ent[DATA_W-1:0]);
            end else begin
                checkOutput("mon_idle_wr_en", wrEn_o, 1'b0);
            end
            if (recoverFlag_i) begin
                b_q.delete();
                exp_a = 1'b0;
            end else begin
                exp_a      = aValid_i & aDestValid_i;
                exp_a_tag  = aPhyDest_i;
                exp_a_data = aData_i;
                if (bValid_i && bReady_o && bDestValid_i)
                    b_q.push_back({bPhyDest_i, bData_i});
            end
        end
    end

    typedef struct {
        logic              a_valid;
        logic              a_dv;
        logic [TAG_W-1:0]  a_tag;
        logic [DATA_W-1:0] a_data;
        logic              b_valid;
        logic              b_dv;
        logic [TAG_W-1:0]  b_tag;
        logic [DATA_W-1:0] b_data;
        logic              exp_en1;
        logic [TAG_W-1:0]  exp_tag1;
        logic [DATA_W-1:0] exp_data1;
        logic              exp_en2;
        logic [TAG_W-1:0]  exp_tag2;
        logic [DATA_W-1:0] exp_data2;
    } vec_t;

    function automatic vec_t mkVec(
        input logic av, input logic adv, input logic [TAG_W-1:0] at, input logic [DATA_W-1:0] ad,
        input logic bv, input logic bdv, input logic [TAG_W-1:0] bt, input logic [DATA_W-1:0] bd,
        input logic e1, input logic [TAG_W-1:0] t1, input logic [DATA_W-1:0] d1,
        input logic e2, input logic [TAG_W-1:0] t2, input logic [DATA_W-1:0] d2);
        vec_t v;
        v.a_valid = av;  v.a_dv = adv;  v.a_tag = at;  v.a_data = ad;
        v.b_valid = bv;  v.b_dv = bdv;  v.b_tag = bt;  v.b_data = bd;
        v.exp_en1 = e1;  v.exp_tag1 = t1;  v.exp_data1 = d1;
        v.exp_en2 = e2;  v.exp_tag2 = t2;  v.exp_data2 = d2;
        return v;
    endfunction

    vec_t vecs [7];

    // Main stimulus sequence.
    initial begin
        logic exp_ready [9];
        int   nb;

        vecs[0] = mkVec(1, 1, 7'd5,  64'h11,  0, 0, 7'd0,  64'h0,    1, 7'd5,  64'h11,   0, 7'd0, 64'h0);
        vecs[1] = mkVec(1, 1, 7'd3,  64'h33,  1, 1, 7'd9,  64'h99,   1, 7'd3,  64'h33,   1, 7'd9, 64'h99);
        vecs[2] = mkVec(1, 0, 7'd10, 64'hAA,  1, 0, 7'd11, 64'hBB,   0, 7'd0,  64'h0,    0, 7'd0, 64'h0);
        vecs[3] = mkVec(1, 0, 7'd10, 64'hAA,  1, 1, 7'd12, 64'h1212, 1, 7'd12, 64'h1212, 0, 7'd0, 64'h0);
        vecs[4] = mkVec(0, 0, 7'd0,  64'h0,   1, 1, 7'd30, 64'h3030, 1, 7'd30, 64'h3030, 0, 7'd0, 64'h0);
        vecs[5] = mkVec(1, 1, 7'd7,  64'h77,  1, 0, 7'd8,  64'h88,   1, 7'd7,  64'h77,   0, 7'd0, 64'h0);
        vecs[6] = mkVec(0, 0, 7'd0,  64'h0,   0, 0, 7'd0,  64'h0,    0, 7'd0,  64'h0,    0, 7'd0, 64'h0);

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_wr_en", wrEn_o, 1'b0);
        checkOutput("reset_wr_addr", wrAddr_o, '0);
        checkOutput("reset_wr_data", wrData_o, '0);
        checkOutput("reset_byp_valid", bypValid_o, 1'b0);
        checkOutput("reset_byp_tag", bypTag_o, '0);
        checkOutput("reset_byp_data", bypData_o, '0);
        checkOutput("reset_b_ready", bReady_o, 1'b1);
        reset = 1'b0;
        repeat (2) idleCycle();

        $display("[TB] table vectors");
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            applyStimulus(1'b0, vecs[i].a_valid, vecs[i].a_dv, vecs[i].a_tag, vecs[i].a_data,
                          vecs[i].b_valid, vecs[i].b_dv, vecs[i].b_tag, vecs[i].b_data);
            idleCycle();
            checkOutput($sformatf("vec%0d_en1", i), wrEn_o, vecs[i].exp_en1);
            if (vecs[i].exp_en1) begin
                checkOutput($sformatf("vec%0d_tag1", i), wrAddr_o, vecs[i].exp_tag1);
                checkOutput($sformatf("vec%0d_data1", i), wrData_o, vecs[i].exp_data1);
                checkOutput($sformatf("vec%0d_byptag1", i), bypTag_o, vecs[i].exp_tag1);
            end
            idleCycle();
            checkOutput($sformatf("vec%0d_en2", i), wrEn_o, vecs[i].exp_en2);
            if (vecs[i].exp_en2) begin
                checkOutput($sformatf("vec%0d_tag2", i), wrAddr_o, vecs[i].exp_tag2);
                checkOutput($sformatf("vec%0d_data2", i), wrData_o, vecs[i].exp_data2);
            end
            checkOutput($sformatf("vec%0d_ready", i), bReady_o, 1'b1);
        end

        $display("[TB] stream: A for 6 cycles, B tags 20..25");
        exp_ready = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        nb = 20;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("stream_ready_c%0d", c), bReady_o, exp_ready[c]);
            applyStimulus(1'b0, c < 6, 1'b1, TAG_W'(40 + c), 64'hA000 + 64'(c),
                          nb <= 25, 1'b1, TAG_W'(nb), 64'hB000 + 64'(nb));
            if (nb <= 25 && bReady_o) nb++;
        end
        checkOutput("stream_accepts", 64'(nb), 64'd26);
        repeat (6) idleCycle();
        checkOutput("stream_drained", 64'(b_q.size()), 64'd0);
        checkOutput("stream_ready_end", bReady_o, 1'b1);

        $display("[TB] recovery with three buffered entries");
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("rec_fill_ready_c%0d", c), bReady_o, 1'b1);
            applyStimulus(1'b0, 1'b1, 1'b1, TAG_W'(60 + c), 64'hC0 + 64'(c),
                          1'b1, 1'b1, TAG_W'(50 + c), 64'hD0 + 64'(c));
        end
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b1, 1'b1, 7'd63, 64'hC3, 1'b1, 1'b1, 7'd53, 64'hD3);
        idleCycle();
        checkOutput("rec_wr_en", wrEn_o, 1'b0);
        checkOutput("rec_ready", bReady_o, 1'b1);
        repeat (6) idleCycle();
        checkOutput("rec_ready_after", bReady_o, 1'b1);

        $display("[TB] asynchronous reset mid-cycle");
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b1, 1'b1, 7'd70, 64'h70, 1'b1, 1'b1, 7'd71, 64'h71);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b1, 1'b1, 7'd72, 64'h72, 1'b1, 1'b1, 7'd73, 64'h73);
        @(posedge clk);
        #3;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        #1;
        checkOutput("async_wr_en", wrEn_o, 1'b0);
        checkOutput("async_wr_addr", wrAddr_o, '0);
        checkOutput("async_wr_data", wrData_o, '0);
        checkOutput("async_byp_valid", bypValid_o, 1'b0);
        checkOutput("async_ready", bReady_o, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) idleCycle();
        checkOutput("post_reset_wr_en", wrEn_o, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b1, 1'b1, 7'd5, 64'h55, 1'b0, 1'b0, '0, '0);
        idleCycle();
        checkOutput("post_reset_a_tag", wrAddr_o, 7'd5);
        repeat (3) idleCycle();
        checkOutput("final_queue_empty", 64'(b_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-back merge stage feeding one physical-register-file write port and its matching bypass packet. It accepts results from two functional-unit streams: a fixed-latency ALU stream (A) that cannot be stalled, and a variable-latency load stream (B) with valid/ready backpressure. It arbitrates them onto a single registered write port and buffers losing B results in an in-order FIFO. It sits between the execute units and the register file / the bypass inputs of the register-read stage.

## Interface
- DATA_W, 64, result data width (matches `SIZE_DATA`)
- TAG_W, 7, physical register tag width (matches `SIZE_PHYSICAL_LOG`)
- DEPTH, 4, B-stream buffer entries; power of two, ≥2
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- recoverFlag_i  in  1  pipeline flush; discards all buffered and in-flight results
- aValid_i  in  1  A result present this cycle
- aDestValid_i  in  1  A result writes a register
- aPhyDest_i  in  TAG_W  A destination tag
- aData_i  in  DATA_W  A result data
- bValid_i  in  1  B result offered
- bDestValid_i  in  1  B result writes a register
- bPhyDest_i  in  TAG_W  B destination tag
- bData_i  in  DATA_W  B result data
- bReady_o  out  1  B result accepted when bValid_i & bReady_o
- wrEn_o  out  1  register-file write enable (registered)
- wrAddr_o  out  TAG_W  write tag (registered)
- wrData_o  out  DATA_W  write data (registered)
- bypValid_o  out  1  bypass packet valid; equals wrEn_o
- bypTag_o  out  TAG_W  bypass tag; equals wrAddr_o
- bypData_o  out  DATA_W  bypass data; equals wrData_o

## Operation
- Effective requests: reqA = aValid_i & aDestValid_i; reqB = bValid_i & bDestValid_i & bReady_o. Results with DestValid=0 are consumed and dropped. B with DestValid=0 still handshakes (ready rule applies).
- bReady_o = (count < DEPTH), using only the registered count. It is not combinational on a same-cycle dequeue, so a full FIFO deasserts ready even while draining.
- Priority each cycle: (1) reqA wins the port. (2) Otherwise, if the FIFO is non-empty, the head dequeues to the port. (3) Otherwise, reqB goes straight to the port with no enqueue.
- reqB not taking the port by rule 3 is enqueued at the tail. This happens when reqA is set or the FIFO is non-empty.
- B results always retire in acceptance order. A is never delayed.
- FIFO: circular buffer with head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus count of log2(DEPTH)+1 bits.
  - Simultaneous enqueue and dequeue leaves count unchanged.
  - Count never exceeds DEPTH and never underflows.
- Output register: loads the winner's {1, tag, data} each cycle, or {0, hold tag, hold data} when no winner. Bypass outputs are wired from the same register.
- recoverFlag_i:
  - Synchronous flush: next edge sets head = tail = count = 0 and wrEn_o = 0.
  - All inputs sampled in that cycle are ignored; a B handshake in that cycle is consumed and dropped.
  - Recovery has priority over every other update.

## Timing
- Reset (async assert) values: wrEn_o = bypValid_o = 0; wrAddr_o = bypTag_o = 0; wrData_o = bypData_o = 0; count/head/tail = 0; bReady_o = 1.
- Latency:
  - A: accepted at cycle t, written at t+1.
  - B direct (idle port, empty FIFO): accepted at t, written at t+1.
  - B buffered: written at t+1+k, where k is the number of cycles the port is occupied by A or older B.
- At most one write per cycle; no write ever duplicates or drops a result outside recovery.
- Reset deasserted mid-operation: the first edge after deassert behaves as normal operation from empty state.

## Test plan
- Reset asserted asynchronously mid-cycle -> all outputs 0 immediately, bReady_o=1; after release, no write until a valid input.
- A only (tag 5, data 0x11) at t -> wrEn_o=1, wrAddr_o=5, wrData_o=0x11, bypTag_o=5 at t+1; wrEn_o=0 at t+2.
- A (tag 3) and B (tag 9) same cycle t -> tag 3 written at t+1, tag 9 written at t+2, count returns to 0.
- A valid every cycle for 6 cycles, B offered every cycle (tags 20..25):
  - bReady_o drops after 4 accepts; tags 20..23 buffered.
  - After A stops, writes 20,21,22,23 in order on consecutive cycles; then tags 24,25 are accepted and written.
- FIFO holds 3 entries, recoverFlag_i pulsed while A and B are valid -> next edge wrEn_o=0, count=0, bReady_o=1; no flushed tag ever appears on wrAddr_o.
- A with aDestValid_i=0 and B with bDestValid_i=0 (bReady_o=1) -> handshake completes, no write, count unchanged; simultaneous B with DestValid=1 is written at t+1.
